// File: rtl/text_link_pipe.sv
// ----------------------------------------------------------------------------
// text_link_pipe
//   Self-contained secure text link between a byte source and a byte sink:
//   stream-cipher encrypt -> fixed-latency channel -> decrypt -> output FIFO.
//   Both keystreams come from identical Galois LFSRs that are seeded with the
//   same key and warmed up together. The decrypt LFSR only steps when a byte
//   leaves the channel, so the two keystreams stay aligned byte for byte.
//   Credit-based flow control means no byte is ever dropped.
//
// Handshake (both ends): a transfer happens on a rising edge where valid and
//   ready are both 1. in_ready never depends on in_valid, and out_valid never
//   depends on out_ready. in_valid/in_data may change freely while in_ready=0.
//
// Ports
//   clk, reset   single clock; synchronous active-high reset
//   key_load     pulse: latch key_in and reload both keystreams once drained
//   key_in       new key (a zero key is replaced by 1)
//   err_inject   flip bit 0 of the ciphertext entering the channel this cycle
//   in_valid/in_data/in_ready     plaintext input
//   out_valid/out_data/out_ready  decrypted output (FIFO head)
//   init_done    keystreams warmed up, link running
//   byte_count   bytes popped at the output, wraps at 16 bits
//
// Debug: the FSM state is held in the signal 'state' (type state_t).
// ----------------------------------------------------------------------------
module text_link_pipe #(
    parameter int                DATA_W     = 8,
    parameter int                LFSR_W     = 16,
    parameter logic [LFSR_W-1:0] KEY_RST    = LFSR_W'(123),
    parameter logic [LFSR_W-1:0] LFSR_POLY  = LFSR_W'(16'hB400),
    parameter int                WARMUP     = 16,
    parameter int                CHAN_LAT   = 4,
    parameter int                FIFO_DEPTH = 8,
    parameter bit                ERR_INJ_EN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              key_load,
    input  logic [LFSR_W-1:0] key_in,
    input  logic              err_inject,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              init_done,
    output logic [15:0]       byte_count
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + CHAN_LAT + 2) + 1;
    localparam int WCNT_W = $clog2(WARMUP + 1);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t state, state_next;

    // Galois right-shift LFSR step.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
        return (v >> 1) ^ (v[0] ? LFSR_POLY : '0);
    endfunction

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    function automatic logic [LFSR_W-1:0] key_fix(input logic [LFSR_W-1:0] k);
        return (k == '0) ? LFSR_W'(1) : k;
    endfunction

    logic [WCNT_W-1:0] warm_cnt;
    logic              warm_last;
    logic [LFSR_W-1:0] key_q, key_next;
    logic [LFSR_W-1:0] enc_lfsr, dec_lfsr;

    logic              enc_valid;
    logic [DATA_W-1:0] enc_q;
    logic [CHAN_LAT-1:0] chan_valid;
    logic [DATA_W-1:0] chan_data [CHAN_LAT];
    logic              dec_valid;
    logic [DATA_W-1:0] dec_q;
    logic [DATA_W-1:0] inj_mask;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [PTR_W:0]    fifo_count;

    logic [CNT_W-1:0]  inflight;
    logic              credit_ok;
    logic              pipe_empty;
    logic              drain_done;
    logic              accept, push, pop;

    // ------------------------------------------------------------------
    // Credit: every byte already accepted owns a FIFO slot, so a byte is
    // only taken when the FIFO plus everything in flight has room.
    // ------------------------------------------------------------------
    always_comb begin
        inflight = CNT_W'(enc_valid) + CNT_W'(dec_valid);
        for (int i = 0; i < CHAN_LAT; i++) begin
            inflight = inflight + CNT_W'(chan_valid[i]);
        end
    end

    assign credit_ok  = (CNT_W'(fifo_count) + inflight) < CNT_W'(FIFO_DEPTH);
    assign pipe_empty = !enc_valid && (chan_valid == '0) && !dec_valid;
    assign warm_last  = (warm_cnt == WCNT_W'(WARMUP - 1));
    assign key_next   = key_load ? key_fix(key_in) : key_q;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_INIT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        init_done  = 1'b0;
        drain_done = 1'b0;
        case (state)
            ST_INIT: begin
                if (warm_last) state_next = ST_RUN;
            end
            ST_RUN: begin
                init_done = 1'b1;
                in_ready  = !key_load && credit_ok;
                if (key_load) state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                // Bytes already in flight still use the old keystream; the
                // reload waits until the decrypt side has consumed them all.
                if (pipe_empty) begin
                    drain_done = 1'b1;
                    state_next = ST_INIT;
                end
            end
            default: state_next = ST_INIT;
        endcase
    end

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset || state != ST_INIT || warm_last) begin
            warm_cnt <= '0;
        end else begin
            warm_cnt <= warm_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            key_q <= key_fix(KEY_RST);
        end else begin
            key_q <= key_next;
        end
    end

    // ------------------------------------------------------------------
    // Keystreams
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            enc_lfsr <= key_fix(KEY_RST);
            dec_lfsr <= key_fix(KEY_RST);
        end else if (state == ST_INIT) begin
            enc_lfsr <= lfsr_step(enc_lfsr);
            dec_lfsr <= lfsr_step(dec_lfsr);
        end else if (drain_done) begin
            enc_lfsr <= key_next;
            dec_lfsr <= key_next;
        end else begin
            if (accept)                enc_lfsr <= lfsr_step(enc_lfsr);
            if (chan_valid[CHAN_LAT-1]) dec_lfsr <= lfsr_step(dec_lfsr);
        end
    end

    // ------------------------------------------------------------------
    // Encrypt register -> channel -> decrypt register
    // ------------------------------------------------------------------
    assign inj_mask = {{(DATA_W-1){1'b0}}, (ERR_INJ_EN && err_inject && enc_valid)};

    always_ff @(posedge clk) begin
        if (reset) begin
            enc_valid  <= 1'b0;
            enc_q      <= '0;
            chan_valid <= '0;
            for (int i = 0; i < CHAN_LAT; i++) chan_data[i] <= '0;
            dec_valid  <= 1'b0;
            dec_q      <= '0;
        end else begin
            enc_valid <= accept;
            if (accept) enc_q <= in_data ^ enc_lfsr[DATA_W-1:0];
            chan_valid[0] <= enc_valid;
            chan_data[0]  <= enc_q ^ inj_mask;
            for (int i = 1; i < CHAN_LAT; i++) begin
                chan_valid[i] <= chan_valid[i-1];
                chan_data[i]  <= chan_data[i-1];
            end
            dec_valid <= chan_valid[CHAN_LAT-1];
            dec_q     <= chan_data[CHAN_LAT-1] ^ dec_lfsr[DATA_W-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO (never flushed by a key reload)
    // ------------------------------------------------------------------
    assign push      = dec_valid;
    assign out_valid = (fifo_count != '0);
    assign pop       = out_valid && out_ready;
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= dec_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            byte_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr     <= rd_ptr + 1'b1;
                byte_count <= byte_count + 16'd1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

endmodule

// File: tb/tb_text_link_pipe.sv
// ----------------------------------------------------------------------------
// tb_text_link_pipe
//   Directed table vectors plus hand-written sequences on a default-parameter
//   instance, and two alternate-parameter instances (CHAN_LAT=1/FIFO_DEPTH=16
//   and CHAN_LAT=7/FIFO_DEPTH=2 with error injection disabled but held high)
//   driven with random traffic against a plaintext scoreboard.
// ----------------------------------------------------------------------------
module tb_text_link_pipe;

  localparam int WARMUP     = 16;
  localparam int CHAN_LAT   = 4;
  localparam int FIFO_DEPTH = 8;
  localparam int ALT_N      = 3000;
  localparam int RND_N      = 1500;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        reset, key_load, err_inject, in_valid, out_ready;
  logic [15:0] key_in;
  logic [7:0]  in_data;
  logic        in_ready, out_valid, init_done;
  logic [7:0]  out_data;
  logic [15:0] byte_count;

  text_link_pipe dut (
    .clk(clk), .reset(reset), .key_load(key_load), .key_in(key_in),
    .err_inject(err_inject), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .init_done(init_done), .byte_count(byte_count)
  );

  // ---------------- scoreboard ----------------
  int         assert_cnt = 0;
  int         fail_cnt   = 0;
  logic [7:0] exp_q[$];
  int         pop_total  = 0;
  logic       lat_arm    = 1'b0;
  int         lat_cyc    = 0;
  int         acc_cyc    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    assert_cnt++;
    if (act !== exp_v) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        assert_cnt++;
        fail_cnt++;
        $display("FAIL out_pop: got 0x%0h expected no byte", out_data);
      end else begin
        check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
      end
      pop_total++;
    end
    if (lat_arm && out_valid) begin
      lat_cyc = cyc;
      lat_arm = 1'b0;
    end
    if (!reset && dut.dec_valid && 32'(dut.fifo_count) == FIFO_DEPTH) begin
      fail_cnt++;
      $display("FAIL full_push: got push at count %0d expected no push", dut.fifo_count);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    err_inject = 1'b0;
  endtask

  // Offers one byte for up to 'budget' cycles. On acceptance the expected
  // output is queued and err (if set) is raised for the following cycle,
  // which is when this byte enters the channel.
  task automatic send_byte(input logic [7:0] d, input logic err, input logic [7:0] expv,
                           input int budget, output logic ok, output logic [7:0] cq);
    logic acc;
    acc = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int n = 0; n < budget && !acc; n++) begin
      @(negedge clk);
      acc = in_ready;
      tick();
    end
    in_valid = 1'b0;
    ok = acc;
    cq = dut.enc_q;
    if (acc) begin
      exp_q.push_back(expv);
      acc_cyc = cyc;
      err_inject = err;
    end
  endtask

  task automatic wait_drain(input int budget);
    for (int n = 0; n < budget && exp_q.size() != 0; n++) tick();
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  function automatic logic [15:0] lfsr_model(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  // ---------------- vector table ----------------
  typedef struct packed {
    logic [7:0] din;
    logic       err;
    logic [7:0] dout;
  } vec_t;

  vec_t vecs [10];

  // ---------------- alternate-parameter instances ----------------
  for (genvar g = 0; g < 2; g++) begin : g_alt
    localparam int A_LAT = (g == 0) ? 1 : 7;
    localparam int A_DEP = (g == 0) ? 16 : 2;
    localparam bit A_EN  = (g == 0);

    logic        a_reset, a_key_load, a_err, a_in_valid, a_in_ready;
    logic        a_out_valid, a_out_ready, a_init_done;
    logic [15:0] a_key_in, a_byte_count;
    logic [7:0]  a_in_data, a_out_data;
    logic [7:0]  a_exp_q[$];
    logic        done = 1'b0;

    text_link_pipe #(.CHAN_LAT(A_LAT), .FIFO_DEPTH(A_DEP), .WARMUP(5), .ERR_INJ_EN(A_EN)) u_alt (
      .clk(clk), .reset(a_reset), .key_load(a_key_load), .key_in(a_key_in),
      .err_inject(a_err), .in_valid(a_in_valid), .in_data(a_in_data),
      .in_ready(a_in_ready), .out_valid(a_out_valid), .out_data(a_out_data),
      .out_ready(a_out_ready), .init_done(a_init_done), .byte_count(a_byte_count)
    );

    initial begin
      int sent;
      int got;
      sent = 0;
      got  = 0;
      a_reset = 1'b1; a_key_load = 1'b0; a_key_in = 16'h0;
      a_err = (g == 1); a_in_valid = 1'b0; a_in_data = 8'h0; a_out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 a_reset = 1'b0;
      for (int c = 0; c < 30000 && got < ALT_N; c++) begin
        a_in_valid  = (sent < ALT_N) && ($urandom_range(0, 3) != 0);
        a_in_data   = 8'($urandom_range(0, 255));
        a_out_ready = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        if (a_in_valid && a_in_ready) begin
          a_exp_q.push_back(a_in_data);
          sent++;
        end
        if (a_out_valid && a_out_ready) begin
          if (a_exp_q.size() == 0) begin
            assert_cnt++;
            fail_cnt++;
            $display("FAIL alt%0d_pop: got 0x%0h expected no byte", g, a_out_data);
          end else begin
            check($sformatf("alt%0d_data", g), 32'(a_out_data), 32'(a_exp_q.pop_front()));
          end
          got++;
        end
        if (u_alt.dec_valid && 32'(u_alt.fifo_count) == A_DEP) begin
          fail_cnt++;
          $display("FAIL alt%0d_full_push: got push at count %0d expected no push", g, u_alt.fifo_count);
        end
        @(posedge clk);
        #1;
      end
      a_in_valid = 1'b0;
      check($sformatf("alt%0d_count", g), 32'(got), 32'(ALT_N));
      check($sformatf("alt%0d_byte_count", g), 32'(a_byte_count), 32'(ALT_N));
      done = 1'b1;
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    logic       ok;
    logic [7:0] cq;
    logic [15:0] l;
    int n, cnt, bad, p0, first_acc, sent;

    vecs[0] = '{din: 8'h48, err: 1'b0, dout: 8'h48};
    vecs[1] = '{din: 8'h45, err: 1'b0, dout: 8'h45};
    vecs[2] = '{din: 8'h4C, err: 1'b0, dout: 8'h4C};
    vecs[3] = '{din: 8'h4C, err: 1'b0, dout: 8'h4C};
    vecs[4] = '{din: 8'h4F, err: 1'b0, dout: 8'h4F};
    vecs[5] = '{din: 8'h10, err: 1'b0, dout: 8'h10};
    vecs[6] = '{din: 8'h20, err: 1'b0, dout: 8'h20};
    vecs[7] = '{din: 8'h30, err: 1'b1, dout: 8'h31};
    vecs[8] = '{din: 8'h40, err: 1'b0, dout: 8'h40};
    vecs[9] = '{din: 8'h50, err: 1'b0, dout: 8'h50};

    reset = 1'b1; key_load = 1'b0; key_in = 16'h0; err_inject = 1'b0;
    in_valid = 1'b0; in_data = 8'h0; out_ready = 1'b0;
    tick();
    tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_init_done", 32'(init_done), 32'd0);
    check("rst_byte_count", 32'(byte_count), 32'd0);
    reset = 1'b0;
    n = 0;
    while (!init_done && n < 100) begin tick(); n++; end
    check("warmup_cycles", 32'(n), 32'(WARMUP));

    // 1: HELLO round trip, latency and byte count
    out_ready = 1'b1;
    lat_arm = 1'b1;
    first_acc = 0;
    for (int i = 0; i < 5; i++) begin
      send_byte(vecs[i].din, vecs[i].err, vecs[i].dout, 20, ok, cq);
      check("t1_accept", 32'(ok), 32'd1);
      if (i == 0) first_acc = acc_cyc;
    end
    wait_drain(50);
    check("t1_latency", 32'(lat_cyc - first_acc), 32'(CHAN_LAT + 2));
    check("t1_byte_count", 32'(byte_count), 32'd5);

    // 2: credit limit with a stalled sink
    out_ready = 1'b0;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      send_byte(8'hA0 + 8'(i), 1'b0, 8'hA0 + 8'(i), 20, ok, cq);
      if (!ok) break;
      cnt++;
    end
    check("t2_accepted", 32'(cnt), 32'(FIFO_DEPTH));
    check("t2_in_ready", 32'(in_ready), 32'd0);
    p0 = pop_total;
    out_ready = 1'b1;
    wait_drain(60);
    check("t2_pops", 32'(pop_total - p0), 32'(FIFO_DEPTH));

    // 3: zero-key reload mid-stream
    send_byte(8'h11, 1'b0, 8'h11, 20, ok, cq);
    send_byte(8'h22, 1'b0, 8'h22, 20, ok, cq);
    send_byte(8'h33, 1'b0, 8'h33, 20, ok, cq);
    key_in = 16'h0000;
    key_load = 1'b1;
    in_valid = 1'b1;
    in_data = 8'hEE;
    #1;
    check("t3_ready_keyload", 32'(in_ready), 32'd0);
    tick();
    key_load = 1'b0;
    key_in = 16'hFFFF;
    bad = 0;
    n = 0;
    while (!init_done && n < 200) begin
      @(negedge clk);
      if (in_ready) bad++;
      tick();
      n++;
    end
    in_valid = 1'b0;
    check("t3_ready_low", 32'(bad), 32'd0);
    check("t3_reinit", 32'(init_done), 32'd1);
    wait_drain(50);
    l = 16'h0001;
    repeat (WARMUP) l = lfsr_model(l);
    for (int i = 0; i < 4; i++) begin
      send_byte(8'h5A + 8'(i * 17), 1'b0, 8'h5A + 8'(i * 17), 20, ok, cq);
      check("t3_accept", 32'(ok), 32'd1);
      check("t3_cipher", 32'(cq), 32'((8'h5A + 8'(i * 17)) ^ l[7:0]));
      l = lfsr_model(l);
    end
    wait_drain(50);

    // 4: single-bit error on the third of five bytes
    for (int i = 5; i < 10; i++) begin
      send_byte(vecs[i].din, vecs[i].err, vecs[i].dout, 20, ok, cq);
      check("t4_accept", 32'(ok), 32'd1);
    end
    wait_drain(50);

    // 5: reset with bytes in flight and in the FIFO
    out_ready = 1'b0;
    send_byte(8'h01, 1'b0, 8'h01, 20, ok, cq);
    send_byte(8'h02, 1'b0, 8'h02, 20, ok, cq);
    repeat (8) tick();
    check("t5_fifo_loaded", 32'(out_valid), 32'd1);
    send_byte(8'h03, 1'b0, 8'h03, 20, ok, cq);
    send_byte(8'h04, 1'b0, 8'h04, 20, ok, cq);
    send_byte(8'h05, 1'b0, 8'h05, 20, ok, cq);
    reset = 1'b1;
    tick();
    check("t5_out_valid", 32'(out_valid), 32'd0);
    check("t5_in_ready", 32'(in_ready), 32'd0);
    check("t5_byte_count", 32'(byte_count), 32'd0);
    check("t5_init_done", 32'(init_done), 32'd0);
    reset = 1'b0;
    exp_q.delete();
    pop_total = 0;
    n = 0;
    while (!init_done && n < 100) begin tick(); n++; end
    check("t5_warmup", 32'(n), 32'(WARMUP));

    // 6: random traffic on the default instance
    sent = 0;
    for (int c = 0; c < 20000 && sent < RND_N; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom_range(0, 255));
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (in_valid && in_ready) begin
        exp_q.push_back(in_data);
        sent++;
      end
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("t6_sent", 32'(sent), 32'(RND_N));
    wait_drain(200);
    check("t6_byte_count", 32'(byte_count), 32'(pop_total & 16'hFFFF));

    n = 0;
    while (!(g_alt[0].done && g_alt[1].done) && n < 40000) begin tick(); n++; end
    check("alt_done", 32'({g_alt[1].done, g_alt[0].done}), 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
